// File: rtl/mapper_pkg.sv
// Shared constants and types for the MMC1 bank controller.
// Register-select codes, mirroring modes and control reset value.
package mapper_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CHR0 = 2'd1;
  localparam logic [1:0] REG_CHR1 = 2'd2;
  localparam logic [1:0] REG_PRG  = 2'd3;

  typedef enum logic [1:0] {
    MIR_ONE_LO = 2'd0,
    MIR_ONE_HI = 2'd1,
    MIR_VERT   = 2'd2,
    MIR_HORZ   = 2'd3
  } mirror_e;

  localparam logic [4:0] CTRL_RESET = 5'h0C;

endpackage

// File: rtl/mmc1_nt_map.sv
// Nametable page mapper: folds a PPU address onto the 4K VRAM.
// Ports: mirror_i mode, addr_i[11:0] PPU address, vrm_o VRAM address.
module mmc1_nt_map
  import mapper_pkg::*;
(
  input  logic [1:0]  mirror_i,
  input  logic [11:0] addr_i,
  output logic [11:0] vrm_o
);

  logic page;

  always_comb begin
    page = 1'b0;
    unique case (mirror_e'(mirror_i))
      MIR_ONE_LO: page = 1'b0;
      MIR_ONE_HI: page = 1'b1;
      MIR_VERT:   page = addr_i[10];
      MIR_HORZ:   page = addr_i[11];
    endcase
  end

  // Only the lower 2K of VRAM is ever addressed.
  assign vrm_o = {1'b0, page, addr_i[9:0]};

endmodule

// File: rtl/mapper_mmc1.sv
// MMC1 bank controller: serial register loader plus PRG/CHR/VRAM maps.
// Ports: CPU write snoop (ce_cpu,cpu_a,cpu_o,cpu_w), PPU addresses in,
//        physical PRG/CHR/VRAM addresses, wram_en and mirror out.
module mapper_mmc1
  import mapper_pkg::*;
#(
  parameter int PRG_BITS = 17,
  parameter int CHR_BITS = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ce_cpu,
  input  logic [15:0]         cpu_a,
  input  logic [7:0]          cpu_o,
  input  logic                cpu_w,
  input  logic [15:0]         prga,
  input  logic [13:0]         chra,
  input  logic [13:0]         vida,
  output logic [PRG_BITS-1:0] prg_addr,
  output logic [CHR_BITS-1:0] chr_a,
  output logic [CHR_BITS-1:0] chr_ax,
  output logic [11:0]         vrm_a,
  output logic [11:0]         vrm_ax,
  output logic                wram_en,
  output logic [1:0]          mirror
);

  localparam int PB = PRG_BITS - 14;
  localparam int CB = CHR_BITS - 12;

  logic [4:0] ctrl_q, ctrl_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q,  prg_d;
  logic [4:0] sr_q,   sr_d;
  logic [2:0] cnt_q,  cnt_d;
  logic       flag_q, flag_d;

  logic       ev;
  logic       acc;
  logic [4:0] shifted;

  assign ev      = ce_cpu & cpu_w & cpu_a[15];
  // Second write of a read-modify-write pair is dropped.
  assign acc     = ev & ~flag_q;
  assign shifted = {cpu_o[0], sr_q[4:1]};

  always_comb begin
    ctrl_d = ctrl_q;
    chr0_d = chr0_q;
    chr1_d = chr1_q;
    prg_d  = prg_q;
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (ce_cpu) flag_d = ev;
    if (acc) begin
      if (cpu_o[7]) begin
        sr_d   = '0;
        cnt_d  = '0;
        ctrl_d = ctrl_q | CTRL_RESET;
      end else if (cnt_q == 3'd4) begin
        sr_d  = '0;
        cnt_d = '0;
        unique case (cpu_a[14:13])
          REG_CTRL: ctrl_d = shifted;
          REG_CHR0: chr0_d = shifted;
          REG_CHR1: chr1_d = shifted;
          REG_PRG:  prg_d  = shifted;
        endcase
      end else begin
        sr_d  = shifted;
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q <= CTRL_RESET;
      chr0_q <= '0;
      chr1_q <= '0;
      prg_q  <= '0;
      sr_q   <= '0;
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      chr0_q <= chr0_d;
      chr1_q <= chr1_d;
      prg_q  <= prg_d;
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  // PRG: prga[14] picks the $8000 or $C000 16K window.
  logic [PB-1:0] prg_bank;

  always_comb begin
    prg_bank = '0;
    unique case (ctrl_q[3:2])
      2'd0, 2'd1: prg_bank = PB'({prg_q[3:1], prga[14]});
      2'd2: prg_bank = prga[14] ? PB'(prg_q[3:0]) : '0;
      2'd3: prg_bank = prga[14] ? '1 : PB'(prg_q[3:0]);
    endcase
  end

  assign prg_addr = {prg_bank, prga[13:0]};

  function automatic logic [CHR_BITS-1:0] chr_map(
    input logic [12:0] a
  );
    logic [4:0] bank;
    if (ctrl_q[4]) bank = a[12] ? chr1_q : chr0_q;
    else           bank = {chr0_q[4:1], a[12]};
    return {CB'(bank), a[11:0]};
  endfunction

  assign chr_a  = chr_map(chra[12:0]);
  assign chr_ax = chr_map(vida[12:0]);

  mmc1_nt_map u_nt_a (
    .mirror_i (ctrl_q[1:0]),
    .addr_i   (chra[11:0]),
    .vrm_o    (vrm_a)
  );

  mmc1_nt_map u_nt_ax (
    .mirror_i (ctrl_q[1:0]),
    .addr_i   (vida[11:0]),
    .vrm_o    (vrm_ax)
  );

  assign wram_en = ~prg_q[4];
  assign mirror  = ctrl_q[1:0];

  logic unused_bits;
  assign unused_bits = ^{prga[15], chra[13], vida[13],
                         cpu_a[12:0], cpu_o[6:1], chr1_q};

endmodule
